ram_dma_ci_strided: RTL
=======================

# ram_dma_ci_strided

Custom-instruction DMA controller with a private dual-port scratch memory, parametrised in memory depth and extended with bus stride (2D gather/scatter), abort-on-error status and a transfer counter. The CPU reaches it through the custom-instruction port (`start`/`ciN`/`valueA`/`valueB`). It masters the shared system bus through the request/grant burst interface to move blocks between bus memory and the scratch memory.

## Interface
- `customId`, 8'd14, `ciN` value this block answers to.
- `MEM_ADDR_BITS`, 9, scratch memory depth = 2^MEM_ADDR_BITS 32-bit words; also locates the CI field split.
- `clock` in 1: sole clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: CI strobe, valid only with `ciN == customId`.
- `ciN` in 8: CI number.
- `valueA` in 32: `[MEM_ADDR_BITS-1:0]` memory address; `[MEM_ADDR_BITS]` write enable; `[MEM_ADDR_BITS+3:MEM_ADDR_BITS+1]` register select.
- `valueB` in 32: write data.
- `done` out 1: CI completion.
- `result` out 32: CI read data.
- `granted` in 1: bus grant.
- `address_data_in` in 32: bus read data.
- `end_transaction_in`, `data_valid_in`, `busy_in`, `error_in` in 1 each: bus slave handshakes.
- `request` out 1: bus request.
- `address_data_out` out 32: bus address (begin cycle) / write data.
- `byte_enables_out` out 4: bus byte enables.
- `burst_size_out` out 8: bus burst size (words − 1).
- `read_n_write_out` out 1: bus direction.
- `begin_transaction_out`, `end_transaction_out`, `data_valid_out` out 1 each: bus master handshakes.

## Operation
- Select 0: scratch memory word.
- Select 1: bus start address, byte address, bits[1:0] forced 0.
- Select 2: memory start address, MEM_ADDR_BITS wide.
- Select 3: block size in words, MEM_ADDR_BITS+1 wide.
- Select 4: burst size, 8 bits, n = n+1 words.
- Select 5: control/status. Write 1 = bus→memory, 2 = memory→bus, 0/3 = no-op. Read = {count[15:0], 13'b0, done_flag, error, busy}.
- Select 6: stride, 32-bit byte offset added to bus address at each burst start. 0 = contiguous (advance by 4×burst words).
- Select 7 reads 0, writes ignored.
- Writes to selects 1–6 are ignored while busy. Memory (select 0) stays accessible while busy. On a same-address, same-cycle write collision, the DMA write wins.
- Control start with block size 0: sets done_flag only, no `request`.
- Starting a transfer clears error, done_flag and count, and sets busy.
- FSM states:
  - IDLE → REQ on start.
  - REQ: `request`=1 until `granted` is sampled 1 → INIT.
  - INIT: one cycle; `begin_transaction_out`=1, `address_data_out`=current bus address, `burst_size_out`=min(burst, remaining)−1, `byte_enables_out`=4'hF, `read_n_write_out`=1 for read.
  - INIT → RD or WR.
  - RD: each cycle with `data_valid_in`=1, write the word at the memory pointer, then pointer+1 (wraps mod 2^MEM_ADDR_BITS), remaining−1, count+1. `end_transaction_in` → NEXT.
  - WR: `data_valid_out`=1 with current word. Advance only on a cycle with `busy_in`=0. After the last word is accepted, END.
  - END: `end_transaction_out`=1 for one cycle → NEXT.
  - NEXT: remaining==0 → IDLE with done_flag=1, busy=0. Otherwise bus address += (stride ? stride : 4×words of last burst) → REQ.
- `error_in` in INIT/RD/WR/END: next state IDLE, all bus outputs 0, error=1, busy=0, count holds.
- Words arriving after `end_transaction_in` or in IDLE are ignored.
- Reset: all registers 0, FSM IDLE. Memory contents are not reset.

## Timing
- All outputs reset to 0.
- `done` is registered: it pulses 1 the cycle after a matching `start`, for every select. `result` is valid in that same cycle and is 0 otherwise.
- Back-to-back CI strobes give back-to-back `done` pulses.
- Bus outputs are registered. `request` rises the cycle after the control write.
- Minimum read burst: 1 INIT cycle + N data cycles + the `end_transaction_in` cycle.
- Minimum write burst: 1 INIT + N data + 1 END cycle.
- Write data holds stable while `busy_in`=1. The first word is presented the cycle after INIT.
- Reset mid-burst drops all bus outputs immediately (asynchronous).

## Test plan
- CI register file: write sel 1 = 0x17, sel 6 = 0x100, mem[0x37] = 0x57, then read each → `done` one cycle later, `result` = 0x14, 0x100, 0x57; `ciN`=7 → no `done`.
- Bus read: bus 0x40, mem 0x40, block 32, burst 7, stride 0, ctrl=1. Four grants with gapped `data_valid_in` → INIT addresses 0x40/0x60/0x80/0xA0, `burst_size_out`=7, mem[0x40..0x5F] = data sequence, status = {32, done, ~busy}.
- Strided write with wrap: mem start 2^MEM_ADDR_BITS−2, block 6, burst 3, stride 0x1000, ctrl=2, `busy_in` toggled → addresses base, base+0x1000; bursts of 4 then 2 words; words read from top-2, top-1, 0, 1, 2, 3; END once per burst.
- Error: block 8, ctrl=1, `error_in` after 3 words → IDLE next cycle, status error=1, count=3, `request`=0; a new ctrl=1 clears error.
- Guards: ctrl=3 → no `request`; ctrl=1 with block 0 → done_flag only; writing sel 3 while busy → value unchanged.
- Reset mid-RD: `reset` pulse → all outputs 0 at once, status reads 0 after release.

Source files
------------

// File: rtl/ram_dma_ci_strided.sv
// Custom-instruction DMA engine: private dual-port scratch RAM, strided bus bursts,
// abort-on-error status and a word transfer counter.
module ram_dma_ci_strided #(
    parameter logic [7:0] customId      = 8'd14,
    parameter int         MEM_ADDR_BITS = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    input  logic        granted,
    input  logic [31:0] address_data_in,
    input  logic        end_transaction_in,
    input  logic        data_valid_in,
    input  logic        busy_in,
    input  logic        error_in,
    output logic        request,
    output logic [31:0] address_data_out,
    output logic [3:0]  byte_enables_out,
    output logic [7:0]  burst_size_out,
    output logic        read_n_write_out,
    output logic        begin_transaction_out,
    output logic        end_transaction_out,
    output logic        data_valid_out
);
    localparam int AW    = MEM_ADDR_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (AW + 1 > 9) ? AW + 1 : 9;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   REM_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CW_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_INIT, S_RD, S_WR, S_END, S_NEXT} state_t;
    state_t state_q;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   bus_addr_q, stride_q, cur_addr_q;
    logic [AW-1:0] mem_start_q, mem_ptr_q;
    logic [AW:0]   block_q, remaining_q;
    logic [7:0]    burst_q;
    logic [CW-1:0] burst_words_q, words_left_q;
    logic          dir_read_q, busy_q, error_q, done_flag_q;
    logic [15:0]   count_q;
    logic          done_q;
    logic [31:0]   result_q;
    logic          request_q, rnw_q, begin_q, end_q, dv_q;
    logic [31:0]   ado_q;
    logic [3:0]    be_q;
    logic [7:0]    bsize_q;

    logic          ci_hit, ci_we, ctrl_go, dma_we, abort;
    logic [2:0]    ci_sel;
    logic [AW-1:0] ci_addr;
    logic [31:0]   ci_rdata, next_addr_d;
    logic [CW-1:0] burst_len_d, rem_ext_d, burst_words_d;
    logic          unused_bits;

    assign ci_hit  = start && (ciN == customId);
    assign ci_we   = valueA[AW];
    assign ci_sel  = valueA[AW+3:AW+1];
    assign ci_addr = valueA[AW-1:0];
    assign ctrl_go = ci_hit && ci_we && (ci_sel == 3'd5) && !busy_q
                     && ((valueB[1:0] == 2'd1) || (valueB[1:0] == 2'd2));
    assign dma_we  = (state_q == S_RD) && data_valid_in && !error_in && (remaining_q != '0);
    assign abort   = error_in && (state_q inside {S_INIT, S_RD, S_WR, S_END});
    assign unused_bits = ^valueA[31:AW+4];

    assign burst_len_d   = CW'(burst_q) + CW_ONE;
    assign rem_ext_d     = CW'(remaining_q);
    assign burst_words_d = (burst_len_d < rem_ext_d) ? burst_len_d : rem_ext_d;
    assign next_addr_d   = cur_addr_q + ((stride_q != '0) ? stride_q : 32'({burst_words_q, 2'b00}));

    always_comb begin
        ci_rdata = '0;
        case (ci_sel)
            3'd0: ci_rdata = mem[ci_addr];
            3'd1: ci_rdata = bus_addr_q;
            3'd2: ci_rdata = 32'(mem_start_q);
            3'd3: ci_rdata = 32'(block_q);
            3'd4: ci_rdata = 32'(burst_q);
            3'd5: ci_rdata = {count_q, 13'b0, done_flag_q, error_q, busy_q};
            3'd6: ci_rdata = stride_q;
            default: ci_rdata = '0;
        endcase
    end

    // The DMA write is issued last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (ci_hit && ci_we && (ci_sel == 3'd0)) mem[ci_addr] <= valueB;
        if (dma_we) mem[mem_ptr_q] <= address_data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bus_addr_q <= '0; stride_q <= '0; cur_addr_q <= '0;
            mem_start_q <= '0; mem_ptr_q <= '0; block_q <= '0; remaining_q <= '0;
            burst_q <= '0; burst_words_q <= '0; words_left_q <= '0;
            dir_read_q <= 1'b0; busy_q <= 1'b0; error_q <= 1'b0; done_flag_q <= 1'b0;
            count_q <= '0; done_q <= 1'b0; result_q <= '0;
            request_q <= 1'b0; rnw_q <= 1'b0; begin_q <= 1'b0; end_q <= 1'b0; dv_q <= 1'b0;
            ado_q <= '0; be_q <= '0; bsize_q <= '0;
        end else begin
            done_q   <= ci_hit;
            result_q <= ci_hit ? ci_rdata : '0;
            if (ci_hit && ci_we && !busy_q) begin
                case (ci_sel)
                    3'd1: bus_addr_q  <= {valueB[31:2], 2'b00};
                    3'd2: mem_start_q <= valueB[AW-1:0];
                    3'd3: block_q     <= valueB[AW:0];
                    3'd4: burst_q     <= valueB[7:0];
                    3'd6: stride_q    <= valueB;
                    default: ;
                endcase
            end
            if (abort) begin
                state_q <= S_IDLE;
                error_q <= 1'b1; busy_q <= 1'b0;
                request_q <= 1'b0; rnw_q <= 1'b0; begin_q <= 1'b0; end_q <= 1'b0; dv_q <= 1'b0;
                ado_q <= '0; be_q <= '0; bsize_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (ctrl_go) begin
                        error_q <= 1'b0; count_q <= '0;
                        if (block_q == '0) begin
                            done_flag_q <= 1'b1;
                        end else begin
                            done_flag_q <= 1'b0; busy_q <= 1'b1;
                            dir_read_q  <= (valueB[1:0] == 2'd1);
                            cur_addr_q  <= bus_addr_q; mem_ptr_q <= mem_start_q;
                            remaining_q <= block_q;
                            request_q   <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                    S_REQ: if (granted) begin
                        request_q <= 1'b0; begin_q <= 1'b1;
                        ado_q <= cur_addr_q; be_q <= 4'hF; rnw_q <= dir_read_q;
                        bsize_q <= 8'(burst_words_d - CW_ONE);
                        burst_words_q <= burst_words_d; words_left_q <= burst_words_d;
                        state_q <= S_INIT;
                    end
                    S_INIT: begin
                        begin_q <= 1'b0; bsize_q <= '0; rnw_q <= 1'b0;
                        if (dir_read_q) begin
                            ado_q <= '0; be_q <= '0; state_q <= S_RD;
                        end else begin
                            ado_q <= mem[mem_ptr_q]; dv_q <= 1'b1; state_q <= S_WR;
                        end
                    end
                    S_RD: begin
                        if (dma_we) begin
                            mem_ptr_q <= mem_ptr_q + PTR_ONE;
                            remaining_q <= remaining_q - REM_ONE;
                            count_q <= count_q + 16'd1;
                        end
                        if (end_transaction_in) state_q <= S_NEXT;
                    end
                    S_WR: if (!busy_in) begin
                        mem_ptr_q <= mem_ptr_q + PTR_ONE;
                        remaining_q <= remaining_q - REM_ONE;
                        count_q <= count_q + 16'd1;
                        words_left_q <= words_left_q - CW_ONE;
                        if (words_left_q == CW_ONE) begin
                            dv_q <= 1'b0; ado_q <= '0; be_q <= '0; end_q <= 1'b1;
                            state_q <= S_END;
                        end else begin
                            ado_q <= mem[mem_ptr_q + PTR_ONE];
                        end
                    end
                    S_END: begin
                        end_q <= 1'b0; state_q <= S_NEXT;
                    end
                    S_NEXT: if (remaining_q == '0) begin
                        done_flag_q <= 1'b1; busy_q <= 1'b0; state_q <= S_IDLE;
                    end else begin
                        cur_addr_q <= next_addr_d; request_q <= 1'b1; state_q <= S_REQ;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign done                  = done_q;
    assign result                = result_q;
    assign request               = request_q;
    assign address_data_out      = ado_q;
    assign byte_enables_out      = be_q;
    assign burst_size_out        = bsize_q;
    assign read_n_write_out      = rnw_q;
    assign begin_transaction_out = begin_q;
    assign end_transaction_out   = end_q;
    assign data_valid_out        = dv_q;
endmodule
